// File: rtl/alu_share_if.sv
// Bundle between the two requesters, the shared ALU and the arbiter.
// slave  : arbiter side (takes requests and ALU result, drives ALU operands and responses)
// master : environment side (requesters plus the ALU instance)
// Signals: req0/req1, a0/a1, b0/b1, fsel0/fsel1 (requests and operands),
//          alu_a/alu_b/alu_fsel (to ALU), alu_o (from ALU),
//          ack0/ack1 (one-cycle response), res (captured result), busy.
interface alu_share_if #(
  parameter int unsigned DW_IN  = 4,
  parameter int unsigned DW_OUT = 8
) ();
  logic              req0;
  logic              req1;
  logic [DW_IN-1:0]  a0;
  logic [DW_IN-1:0]  a1;
  logic [DW_IN-1:0]  b0;
  logic [DW_IN-1:0]  b1;
  logic [1:0]        fsel0;
  logic [1:0]        fsel1;
  logic [DW_IN-1:0]  alu_a;
  logic [DW_IN-1:0]  alu_b;
  logic [1:0]        alu_fsel;
  logic [DW_OUT-1:0] alu_o;
  logic              ack0;
  logic              ack1;
  logic [DW_OUT-1:0] res;
  logic              busy;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, fsel0, fsel1, alu_o,
    output alu_a, alu_b, alu_fsel, ack0, ack1, res, busy
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, fsel0, fsel1, alu_o,
    input  alu_a, alu_b, alu_fsel, ack0, ack1, res, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Grants in IDLE, holds operands for ALU_LAT+1 cycles in WAIT, captures the
// ALU result and pulses the winner's ack for one cycle in RESP.
// Ports: clk, rst (synchronous, active-low), bus (alu_share_if.slave).
// Parameter: ALU_LAT = ALU latency in cycles (0..15).
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_share_if.slave bus
);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ptr;   // requester favoured on contention
  logic          win;   // requester owning the in-flight op
  logic          pick1_c;

  // req1 wins when it is alone or when both request and the pointer favours it
  assign pick1_c = bus.req1 && (!bus.req0 || ptr);

  // Arbitration FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= 1'b0;
      win          <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_fsel <= '0;
      bus.res      <= '0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            win          <= pick1_c;
            bus.alu_a    <= pick1_c ? bus.a1    : bus.a0;
            bus.alu_b    <= pick1_c ? bus.b1    : bus.b0;
            bus.alu_fsel <= pick1_c ? bus.fsel1 : bus.fsel0;
            cnt          <= CW'(ALU_LAT);
            state        <= WAIT;
            bus.busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.res  <= bus.alu_o;
            bus.ack0 <= !win;
            bus.ack1 <= win;
            state    <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          ptr      <= !win;
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one arbiter with a 1-cycle ALU stub, one with a 3-cycle stub.
module tb_alu_share_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_share_if #(.DW_IN(4), .DW_OUT(8)) i0 ();
  alu_share_if #(.DW_IN(4), .DW_OUT(8)) i1 ();

  alu_share_arbiter #(.ALU_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  alu_share_arbiter #(.ALU_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] f);
    case (f)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) - 8'(b);
      2'b10:   return 8'(a & b);
      default: return 8'(a) * 8'(b);
    endcase
  endfunction

  // ALU stubs: latency 1 and latency 3
  logic [7:0] p1, p2;
  always_ff @(posedge clk) i0.alu_o <= alu_f(i0.alu_a, i0.alu_b, i0.alu_fsel);
  always_ff @(posedge clk) begin
    p1       <= alu_f(i1.alu_a, i1.alu_b, i1.alu_fsel);
    p2       <= p1;
    i1.alu_o <= p2;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] sweep_exp [4];

  initial begin
    checks = 0;
    failures = 0;
    sweep_exp[0] = 8'h06; sweep_exp[1] = 8'h02; sweep_exp[2] = 8'h00; sweep_exp[3] = 8'h08;
    rst = 1'b0;
    i0.req0 = 1'b1; i0.a0 = 4'd4; i0.b0 = 4'd2; i0.fsel0 = 2'b00;
    i0.req1 = 1'b1; i0.a1 = 4'd3; i0.b1 = 4'd5; i0.fsel1 = 2'b11;
    i1.req0 = 1'b0; i1.a0 = 4'd0; i1.b0 = 4'd0; i1.fsel0 = 2'b00;
    i1.req1 = 1'b0; i1.a1 = 4'd0; i1.b1 = 4'd0; i1.fsel1 = 2'b00;

    // Reset held two cycles with requests high
    cyc(); cyc();
    chk("rst_alu_a", 32'(i0.alu_a), 32'h0);
    chk("rst_alu_b", 32'(i0.alu_b), 32'h0);
    chk("rst_alu_fsel", 32'(i0.alu_fsel), 32'h0);
    chk("rst_res", 32'(i0.res), 32'h0);
    chk("rst_acks", 32'({i0.ack0, i0.ack1}), 32'h0);
    chk("rst_busy", 32'(i0.busy), 32'h0);
    chk("rst_busy_lat3", 32'(i1.busy), 32'h0);

    // Continuous contention from reset: acks 0,1,0,1, each op IDLE..RESP in 4 cycles
    rst = 1'b1;
    cyc();
    chk("c1_busy", 32'(i0.busy), 32'h1);
    chk("c1_alu_a", 32'(i0.alu_a), 32'h4);
    cyc();
    chk("c1_noack", 32'({i0.ack0, i0.ack1}), 32'h0);
    cyc();
    chk("c1_acks", 32'({i0.ack0, i0.ack1}), 32'h2);
    chk("c1_res", 32'(i0.res), 32'h06);
    cyc();
    chk("c1_idle_busy", 32'(i0.busy), 32'h0);
    chk("c1_idle_ack", 32'({i0.ack0, i0.ack1}), 32'h0);
    cyc();
    chk("c2_ops", 32'({i0.alu_a, i0.alu_b, 2'b00, i0.alu_fsel}), 32'h353);
    cyc(); cyc();
    chk("c2_acks", 32'({i0.ack0, i0.ack1}), 32'h1);
    chk("c2_res", 32'(i0.res), 32'h0F);
    cyc(); cyc();
    chk("c3_alu_a", 32'(i0.alu_a), 32'h4);
    i0.a0 = 4'd9;                     // operand change after grant must be ignored
    cyc(); cyc();
    chk("c3_acks", 32'({i0.ack0, i0.ack1}), 32'h2);
    chk("c3_res", 32'(i0.res), 32'h06);
    i0.a0 = 4'd4;
    cyc(); cyc(); cyc(); cyc();
    chk("c4_acks", 32'({i0.ack0, i0.ack1}), 32'h1);
    chk("c4_res", 32'(i0.res), 32'h0F);
    i0.req0 = 1'b0; i0.req1 = 1'b0;
    cyc(); cyc();
    chk("quiet_busy", 32'(i0.busy), 32'h0);

    // req0 alone, fsel sweep
    i0.req0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i0.fsel0 = 2'(k);
      cyc();
      chk("sw_busy", 32'(i0.busy), 32'h1);
      cyc();
      chk("sw_noack", 32'(i0.ack0), 32'h0);
      cyc();
      chk("sw_ack", 32'({i0.ack0, i0.ack1}), 32'h2);
      chk("sw_res", 32'(i0.res), 32'(sweep_exp[k]));
      if (k == 3) i0.req0 = 1'b0;
      cyc();
      chk("sw_idle", 32'({i0.busy, i0.ack0}), 32'h0);
    end

    // req1 granted alone, req0 rises during its WAIT and gets the next grant
    i0.fsel0 = 2'b00;
    i0.req1 = 1'b1;
    cyc();
    chk("l_r1_alu_a", 32'(i0.alu_a), 32'h3);
    i0.req0 = 1'b1;
    cyc(); cyc();
    chk("l_r1_ack", 32'({i0.ack0, i0.ack1}), 32'h1);
    cyc(); cyc();
    chk("l_r0_alu_a", 32'(i0.alu_a), 32'h4);
    cyc(); cyc();
    chk("l_r0_ack", 32'({i0.ack0, i0.ack1}), 32'h2);

    // Pointer now favours req1; reset mid-WAIT discards the op and restores req0 priority
    cyc(); cyc();
    chk("r_r1_alu_a", 32'(i0.alu_a), 32'h3);
    rst = 1'b0;
    cyc();
    chk("r_busy", 32'(i0.busy), 32'h0);
    chk("r_acks", 32'({i0.ack0, i0.ack1}), 32'h0);
    chk("r_alu_a", 32'(i0.alu_a), 32'h0);
    rst = 1'b1;
    cyc();
    chk("r_win0", 32'({i0.busy, i0.alu_a}), 32'h14);
    cyc();
    chk("r_noack", 32'({i0.ack0, i0.ack1}), 32'h0);
    cyc();
    chk("r_ack0", 32'({i0.ack0, i0.ack1}), 32'h2);
    chk("r_res", 32'(i0.res), 32'h06);
    i0.req0 = 1'b0; i0.req1 = 1'b0;
    cyc();

    // ALU_LAT=3: ack1 at t+5, busy t+1..t+5; req1 dropped after grant
    i1.req1 = 1'b1; i1.a1 = 4'd4; i1.b1 = 4'd2; i1.fsel1 = 2'b11;
    for (int n = 1; n <= 7; n++) begin
      cyc();
      if (n == 1) i1.req1 = 1'b0;
      chk("l3_busy", 32'(i1.busy), (n <= 5) ? 32'h1 : 32'h0);
      chk("l3_acks", 32'({i1.ack0, i1.ack1}), (n == 5) ? 32'h1 : 32'h0);
      if (n == 5) chk("l3_res", 32'(i1.res), 32'h08);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
